conv_window_mac: RTL and testbench

Downstream consumer of `top_memory` in the TTPU datapath. For each of `NUM_UNITS` parallel lanes, it takes the image pixel stream (`out_1`) and the kernel weight stream (`out_2`) that the memory emits. It multiply-accumulates exactly `kernel_dim*kernel_dim` operand pairs per convolution window and presents one accumulated result per lane through a valid/ready handshake to the next stage (activation/writeback).

---
 rtl/ttpu_pkg.sv | 23 ++
 rtl/conv_window_mac_if.sv | 40 ++++
 rtl/mac_lane.sv | 62 ++++++
 rtl/conv_window_mac.sv | 119 +++++++++++
 tb/tb_conv_window_mac.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ttpu_pkg.sv
// ---------------------------------------------------------------------------
// ttpu_pkg
// Shared definitions for the TTPU convolution MAC datapath.
//   mac_state_t        : window controller states (IDLE / ACCUM / DONE)
//   DEFAULT_ACC_WIDTH  : default accumulator / result width
//   TAP_CNT_W()        : tap counter width, sized to hold IMAGE_WIDTH^2 taps
// ---------------------------------------------------------------------------
package ttpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } mac_state_t;

    localparam int DEFAULT_ACC_WIDTH = 40;

    // The counter must represent a full IMAGE_WIDTH x IMAGE_WIDTH window.
    function automatic int TAP_CNT_W(input int image_width);
        return $clog2(image_width * image_width + 1);
    endfunction

endpackage

// File: rtl/conv_window_mac_if.sv
// ---------------------------------------------------------------------------
// conv_window_mac_if
// Operand stream + result handshake bundle for conv_window_mac.
//   start, kernel_dim       : open a window of kernel_dim x kernel_dim taps
//   in_valid, pixel_in,
//   weight_in               : one operand pair per lane, packed lane-major
//   busy                    : MAC is in ACCUM or DONE
//   out_valid, out_ready,
//   result                  : per-lane accumulated sums, packed lane-major
// Modports: master = controller/consumer side, slave = the MAC.
// ---------------------------------------------------------------------------
interface conv_window_mac_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int IMAGE_WIDTH = 8,
    parameter int NUM_UNITS   = 2,
    parameter int ACC_WIDTH   = ttpu_pkg::DEFAULT_ACC_WIDTH
);
    localparam int KD_W = $clog2(IMAGE_WIDTH);

    logic                            start;
    logic [KD_W-1:0]                 kernel_dim;
    logic                            in_valid;
    logic [NUM_UNITS*DATA_WIDTH-1:0] pixel_in;
    logic [NUM_UNITS*DATA_WIDTH-1:0] weight_in;
    logic                            busy;
    logic                            out_valid;
    logic                            out_ready;
    logic [NUM_UNITS*ACC_WIDTH-1:0]  result;

    modport master (
        output start, kernel_dim, in_valid, pixel_in, weight_in, out_ready,
        input  busy, out_valid, result
    );

    modport slave (
        input  start, kernel_dim, in_valid, pixel_in, weight_in, out_ready,
        output busy, out_valid, result
    );

endinterface

// File: rtl/mac_lane.sv
// ---------------------------------------------------------------------------
// mac_lane
// One signed multiplier feeding a wrapping accumulator, plus a result
// register that captures the final sum of a window.
//   clk, reset : clock, asynchronous active-low reset
//   clear      : zero the accumulator (start of window)
//   acc_en     : add pixel*weight into the accumulator
//   capture    : load result with the sum including this cycle's product;
//                with clear also high, result is loaded with zero (empty window)
//   pixel,
//   weight     : signed operands
//   result     : captured window sum
// ---------------------------------------------------------------------------
module mac_lane #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  acc_en,
    input  logic                  capture,
    input  logic [DATA_WIDTH-1:0] pixel,
    input  logic [DATA_WIDTH-1:0] weight,
    output logic [ACC_WIDTH-1:0]  result
);

    logic signed [DATA_WIDTH-1:0]   pixel_s;
    logic signed [DATA_WIDTH-1:0]   weight_s;
    logic signed [2*DATA_WIDTH-1:0] product;
    logic signed [ACC_WIDTH-1:0]    product_ext;
    logic signed [ACC_WIDTH-1:0]    acc_reg;
    logic signed [ACC_WIDTH-1:0]    acc_next;
    logic        [ACC_WIDTH-1:0]    result_reg;

    assign pixel_s     = pixel;
    assign weight_s    = weight;
    assign product     = pixel_s * weight_s;
    // Size cast of a signed value sign-extends the product.
    assign product_ext = ACC_WIDTH'(product);
    // Wraps modulo 2^ACC_WIDTH by construction.
    assign acc_next    = acc_reg + product_ext;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_reg    <= '0;
            result_reg <= '0;
        end else begin
            if (clear) begin
                acc_reg <= '0;
            end else if (acc_en) begin
                acc_reg <= acc_next;
            end
            if (capture) begin
                result_reg <= clear ? '0 : acc_next;
            end
        end
    end

    assign result = result_reg;

endmodule

// File: rtl/conv_window_mac.sv
// ---------------------------------------------------------------------------
// conv_window_mac
// Per-lane multiply-accumulate over one kernel_dim x kernel_dim window,
// result presented through a valid/ready handshake.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   en    : global enable; low freezes every register and ignores inputs
//   bus   : conv_window_mac_if.slave (start/kernel_dim, operand stream,
//           busy, out_valid/out_ready/result)
// The FSM, tap counter and handshake live here; the lanes only do
// arithmetic under the shared clear / acc_en / capture strobes.
// ---------------------------------------------------------------------------
module conv_window_mac
    import ttpu_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int IMAGE_WIDTH = 8,
    parameter int NUM_UNITS   = 2,
    parameter int ACC_WIDTH   = DEFAULT_ACC_WIDTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    conv_window_mac_if.slave bus
);

    localparam int TAP_W = TAP_CNT_W(IMAGE_WIDTH);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ACCUM = ACCUM;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [1:0]       state_reg, state_next;
    logic [TAP_W-1:0] cnt_reg, cnt_next;
    logic [TAP_W-1:0] taps_reg, taps_next;
    logic             out_valid_reg, out_valid_next;

    logic [TAP_W-1:0] new_taps;
    logic [TAP_W-1:0] cnt_plus;
    logic             handshake;
    logic             start_fire;
    logic             pair_fire;
    logic             last_pair;
    logic             empty_window;

    assign new_taps  = TAP_W'(bus.kernel_dim) * TAP_W'(bus.kernel_dim);
    assign cnt_plus  = cnt_reg + 1'b1;

    // Every strobe is qualified by en so a disabled cycle changes nothing.
    assign handshake    = en && (state_reg == ST_DONE) && out_valid_reg && bus.out_ready;
    assign start_fire   = bus.start && ((en && (state_reg == ST_IDLE)) || handshake);
    assign pair_fire    = en && (state_reg == ST_ACCUM) && bus.in_valid;
    assign last_pair    = pair_fire && (cnt_plus == taps_reg);
    assign empty_window = start_fire && (new_taps == '0);

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        taps_next      = taps_reg;
        out_valid_next = out_valid_reg;
        if (start_fire) begin
            cnt_next  = '0;
            taps_next = new_taps;
            if (new_taps == '0) begin
                state_next     = ST_DONE;
                out_valid_next = 1'b1;
            end else begin
                state_next     = ST_ACCUM;
                out_valid_next = 1'b0;
            end
        end else if (pair_fire) begin
            cnt_next = cnt_plus;
            if (last_pair) begin
                state_next     = ST_DONE;
                out_valid_next = 1'b1;
            end
        end else if (handshake) begin
            state_next     = ST_IDLE;
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            taps_reg      <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            taps_reg      <= taps_next;
            out_valid_reg <= out_valid_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_UNITS; gi++) begin : g_lane
            mac_lane #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH)
            ) u_lane (
                .clk     (clk),
                .reset   (reset),
                .clear   (start_fire),
                .acc_en  (pair_fire),
                .capture (last_pair || empty_window),
                .pixel   (bus.pixel_in[gi*DATA_WIDTH +: DATA_WIDTH]),
                .weight  (bus.weight_in[gi*DATA_WIDTH +: DATA_WIDTH]),
                .result  (bus.result[gi*ACC_WIDTH +: ACC_WIDTH])
            );
        end
    endgenerate

    assign bus.busy      = (state_reg != ST_IDLE);
    assign bus.out_valid = out_valid_reg;

endmodule

// File: tb/tb_conv_window_mac.sv
// ---------------------------------------------------------------------------
// tb_conv_window_mac
// Self-checking bench for conv_window_mac. Expected sums come from a
// behavioural model: the plain arithmetic sum of pixel*weight over the pairs
// the bench knows should count, reduced modulo 2^ACC_WIDTH.
// ---------------------------------------------------------------------------
module tb_conv_window_mac;

    localparam int DW   = 16;
    localparam int IW   = 8;
    localparam int NU   = 2;
    localparam int ACC  = 40;
    localparam int KD_W = $clog2(IW);

    logic clk;
    logic reset;
    logic en;

    conv_window_mac_if #(
        .DATA_WIDTH (DW),
        .IMAGE_WIDTH(IW),
        .NUM_UNITS  (NU),
        .ACC_WIDTH  (ACC)
    ) bus ();

    conv_window_mac #(
        .DATA_WIDTH (DW),
        .IMAGE_WIDTH(IW),
        .NUM_UNITS  (NU),
        .ACC_WIDTH  (ACC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     n_tests;
    int     n_fail;
    longint exp_acc [NU];

    // Inputs are driven and outputs sampled 1 time unit after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NU*DW-1:0] rand_vec();
        logic [NU*DW-1:0] v;
        for (int u = 0; u < NU; u++) v[u*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    function automatic void model_clear();
        for (int u = 0; u < NU; u++) exp_acc[u] = 0;
    endfunction

    function automatic void model_add(input logic [NU*DW-1:0] pv, input logic [NU*DW-1:0] wv);
        logic signed [DW-1:0] a;
        logic signed [DW-1:0] b;
        for (int u = 0; u < NU; u++) begin
            a = pv[u*DW +: DW];
            b = wv[u*DW +: DW];
            exp_acc[u] += longint'(a) * longint'(b);
        end
    endfunction

    // Open a window; the in_valid pulse in the start cycle carries junk that
    // must not be counted.
    task automatic start_window(input int kd);
        bus.start      = 1'b1;
        bus.kernel_dim = KD_W'(kd);
        bus.in_valid   = 1'b1;
        bus.pixel_in   = rand_vec();
        bus.weight_in  = rand_vec();
        step();
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        model_clear();
    endtask

    task automatic send_pair(input logic [NU*DW-1:0] pv, input logic [NU*DW-1:0] wv, input bit counted);
        bus.in_valid  = 1'b1;
        bus.pixel_in  = pv;
        bus.weight_in = wv;
        if (counted) model_add(pv, wv);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset();
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        n_tests++; if (bus.result !== '0) begin n_fail++; $display("FAIL reset_result got=%h want=0", bus.result); end
        $display("[TB] reset state checked");
    endtask

    task automatic test_kd1();
        logic [NU*DW-1:0] pv;
        logic [NU*DW-1:0] wv;
        start_window(1);
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL kd1_busy got=%b want=1", bus.busy); end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL kd1_early_valid got=%b want=0", bus.out_valid); end
        pv = {16'd12, 16'd6};
        wv = {16'd3, 16'd3};
        send_pair(pv, wv, 1'b1);
        n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL kd1_out_valid got=%b want=1", bus.out_valid); end
        n_tests++; if (bus.result[0 +: ACC] !== 40'd18) begin n_fail++; $display("FAIL kd1_lane0 got=%0d want=18", bus.result[0 +: ACC]); end
        n_tests++; if (bus.result[ACC +: ACC] !== 40'd36) begin n_fail++; $display("FAIL kd1_lane1 got=%0d want=36", bus.result[ACC +: ACC]); end
        $display("[TB] kd=1 window result lane0=%0d lane1=%0d", bus.result[0 +: ACC], bus.result[ACC +: ACC]);
        handshake();
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL kd1_hs_valid got=%b want=0", bus.out_valid); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL kd1_hs_busy got=%b want=0", bus.busy); end
    endtask

    task automatic test_kd3_gaps();
        logic [NU*DW-1:0] pv;
        logic [NU*DW-1:0] wv;
        logic [ACC-1:0]   e;
        start_window(3);
        for (int i = 0; i < 9; i++) begin
            pv = rand_vec();
            wv = rand_vec();
            pv[0 +: DW] = DW'(3 * i);
            wv[0 +: DW] = 16'd1;
            if (i == 8) begin
                n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL kd3_valid_before_9th got=%b want=0", bus.out_valid); end
            end
            send_pair(pv, wv, 1'b1);
            if (i != 8) step();
        end
        n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL kd3_out_valid got=%b want=1", bus.out_valid); end
        n_tests++; if (bus.result[0 +: ACC] !== 40'd108) begin n_fail++; $display("FAIL kd3_lane0 got=%0d want=108", bus.result[0 +: ACC]); end
        e = exp_acc[1][ACC-1:0];
        n_tests++; if (bus.result[ACC +: ACC] !== e) begin n_fail++; $display("FAIL kd3_lane1 got=%h want=%h", bus.result[ACC +: ACC], e); end
        $display("[TB] kd=3 gapped window lane0=%0d", bus.result[0 +: ACC]);
        handshake();
    endtask

    task automatic test_signed();
        start_window(1);
        send_pair({-16'sd3, -16'sd2}, {-16'sd4, 16'sd5}, 1'b1);
        n_tests++; if (bus.result[0 +: ACC] !== 40'hFF_FFFF_FFF6) begin n_fail++; $display("FAIL signed_lane0 got=%h want=fffffffff6", bus.result[0 +: ACC]); end
        n_tests++; if (bus.result[ACC +: ACC] !== 40'd12) begin n_fail++; $display("FAIL signed_lane1 got=%h want=000000000c", bus.result[ACC +: ACC]); end
        $display("[TB] signed window lane0=%h lane1=%h", bus.result[0 +: ACC], bus.result[ACC +: ACC]);
        handshake();
    endtask

    task automatic test_kd0();
        start_window(0);
        n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL kd0_out_valid got=%b want=1", bus.out_valid); end
        n_tests++; if (bus.result !== '0) begin n_fail++; $display("FAIL kd0_result got=%h want=0", bus.result); end
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL kd0_busy got=%b want=1", bus.busy); end
        $display("[TB] kd=0 window result=%h", bus.result);
        handshake();
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL kd0_hs_busy got=%b want=0", bus.busy); end
    endtask

    task automatic test_random();
        int kd;
        int taps;
        logic [ACC-1:0] e;
        for (int w = 0; w < 8; w++) begin
            kd   = $urandom_range(1, 7);
            taps = kd * kd;
            // in_valid while idle must be ignored
            send_pair(rand_vec(), rand_vec(), 1'b0);
            start_window(kd);
            for (int i = 0; i < taps; i++) begin
                if (i == taps - 1) begin
                    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rand_early_valid w=%0d got=%b want=0", w, bus.out_valid); end
                end
                send_pair(rand_vec(), rand_vec(), 1'b1);
                if (i != taps - 1) begin
                    for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                        // stray start during ACCUM must not restart the window
                        bus.start      = $urandom_range(0, 1) == 1;
                        bus.kernel_dim = KD_W'($urandom);
                        step();
                        bus.start = 1'b0;
                    end
                end
            end
            n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rand_out_valid w=%0d got=%b want=1", w, bus.out_valid); end
            for (int u = 0; u < NU; u++) begin
                e = exp_acc[u][ACC-1:0];
                n_tests++; if (bus.result[u*ACC +: ACC] !== e) begin n_fail++; $display("FAIL rand_lane%0d w=%0d got=%h want=%h", u, w, bus.result[u*ACC +: ACC], e); end
            end
            $display("[TB] random window %0d kd=%0d lane0=%h lane1=%h", w, kd, bus.result[0 +: ACC], bus.result[ACC +: ACC]);
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) step();
            handshake();
        end
    endtask

    task automatic test_back_to_back();
        logic [NU*DW-1:0] held;
        logic [ACC-1:0]   e;
        start_window(2);
        for (int i = 0; i < 4; i++) send_pair(rand_vec(), rand_vec(), 1'b1);
        held = '0;
        for (int i = 0; i < 5; i++) begin
            bus.out_ready  = 1'b0;
            bus.start      = 1'b1;
            bus.kernel_dim = KD_W'($urandom);
            send_pair(rand_vec(), rand_vec(), 1'b0);
            bus.start = 1'b0;
            n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid c=%0d got=%b want=1", i, bus.out_valid); end
            for (int u = 0; u < NU; u++) begin
                e = exp_acc[u][ACC-1:0];
                n_tests++; if (bus.result[u*ACC +: ACC] !== e) begin n_fail++; $display("FAIL bp_lane%0d c=%0d got=%h want=%h", u, i, bus.result[u*ACC +: ACC], e); end
            end
        end
        // handshake plus start in one cycle: straight into ACCUM
        bus.out_ready  = 1'b1;
        bus.start      = 1'b1;
        bus.kernel_dim = 3'd1;
        step();
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        model_clear();
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid got=%b want=0", bus.out_valid); end
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got=%b want=1", bus.busy); end
        send_pair(rand_vec(), rand_vec(), 1'b1);
        n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_out_valid got=%b want=1", bus.out_valid); end
        for (int u = 0; u < NU; u++) begin
            e = exp_acc[u][ACC-1:0];
            n_tests++; if (bus.result[u*ACC +: ACC] !== e) begin n_fail++; $display("FAIL b2b_lane%0d got=%h want=%h", u, bus.result[u*ACC +: ACC], e); end
        end
        $display("[TB] back-to-back window lane0=%h lane1=%h", bus.result[0 +: ACC], bus.result[ACC +: ACC]);
        handshake();
    endtask

    task automatic test_reset_mid();
        logic [ACC-1:0] e;
        start_window(3);
        for (int i = 0; i < 4; i++) send_pair(rand_vec(), rand_vec(), 1'b1);
        reset = 1'b0;
        #1;
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b want=0", bus.busy); end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got=%b want=0", bus.out_valid); end
        n_tests++; if (bus.result !== '0) begin n_fail++; $display("FAIL rstmid_result got=%h want=0", bus.result); end
        step();
        reset = 1'b1;
        step();
        start_window(3);
        for (int i = 0; i < 9; i++) send_pair(rand_vec(), rand_vec(), 1'b1);
        n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_fresh_valid got=%b want=1", bus.out_valid); end
        for (int u = 0; u < NU; u++) begin
            e = exp_acc[u][ACC-1:0];
            n_tests++; if (bus.result[u*ACC +: ACC] !== e) begin n_fail++; $display("FAIL rstmid_lane%0d got=%h want=%h", u, bus.result[u*ACC +: ACC], e); end
        end
        $display("[TB] window after mid-window reset lane0=%h", bus.result[0 +: ACC]);
        handshake();
    endtask

    task automatic test_enable();
        logic [ACC-1:0] e;
        start_window(2);
        send_pair(rand_vec(), rand_vec(), 1'b1);
        send_pair(rand_vec(), rand_vec(), 1'b1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid  = (i != 1);
            bus.pixel_in  = rand_vec();
            bus.weight_in = rand_vec();
            step();
            n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL en_busy c=%0d got=%b want=1", i, bus.busy); end
        end
        bus.in_valid = 1'b0;
        en = 1'b1;
        send_pair(rand_vec(), rand_vec(), 1'b1);
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL en_early_valid got=%b want=0", bus.out_valid); end
        send_pair(rand_vec(), rand_vec(), 1'b1);
        n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL en_out_valid got=%b want=1", bus.out_valid); end
        for (int u = 0; u < NU; u++) begin
            e = exp_acc[u][ACC-1:0];
            n_tests++; if (bus.result[u*ACC +: ACC] !== e) begin n_fail++; $display("FAIL en_lane%0d got=%h want=%h", u, bus.result[u*ACC +: ACC], e); end
        end
        $display("[TB] enable-gated window lane0=%h lane1=%h", bus.result[0 +: ACC], bus.result[ACC +: ACC]);
        // out_ready while disabled is ignored
        en = 1'b0;
        handshake();
        n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL en_hold_valid got=%b want=1", bus.out_valid); end
        en = 1'b1;
        handshake();
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL en_release_valid got=%b want=0", bus.out_valid); end
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        reset          = 1'b0;
        en             = 1'b1;
        bus.start      = 1'b0;
        bus.kernel_dim = '0;
        bus.in_valid   = 1'b0;
        bus.pixel_in   = '0;
        bus.weight_in  = '0;
        bus.out_ready  = 1'b0;
        model_clear();
        step();
        step();
        test_reset();
        reset = 1'b1;
        step();
        test_kd1();
        test_kd3_gaps();
        test_signed();
        test_kd0();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_enable();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
